// File: rtl/motor_pkg.sv
// ============================================================================
// Module      : motor_pkg
// Description : Shared types, default constants and the saturating-add helper
//               for the motor speed loop (speed_loop_controller and friends).
// Contents    : loop_state_t  - 3-bit speed-loop sequencer state encoding
//               c_*           - default parameter values
//               sat_add()     - add with clamp into [0, max_val]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package motor_pkg;

  localparam int c_WINDOW_CYCLES = 50000;  // 1 ms at 50 MHz
  localparam int c_COUNT_W       = 8;
  localparam int c_DUTY_W        = 8;
  localparam int c_GAIN_SHIFT    = 2;
  localparam int c_STALL_WINDOWS = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_MEASURE = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_UPDATE  = 3'd4
  } loop_state_t;

  // Signed add clamped to [0, max_val]. The 32-bit working width is wider
  // than duty + step can ever need, so the intermediate sum never wraps.
  function automatic int sat_add(input int base, input int step, input int max_val);
    int sum;
    sum = base + step;
    if (sum < 0) begin
      return 0;
    end
    if (sum > max_val) begin
      return max_val;
    end
    return sum;
  endfunction

endpackage

`default_nettype wire

// File: rtl/speed_loop_controller_if.sv
// ============================================================================
// Module      : speed_loop_controller_if
// Description : Signal bundle between the speed-loop controller, the encoder
//               up/down counter and the motor driver.
// Signals     : enable, target_speed, encoder_count   (master -> controller)
//               count_clear, measured_speed, speed_valid,
//               duty, pwm_out, fault                    (controller -> master)
// Modports    : master - system side driving requests and encoder data
//               slave  - the speed_loop_controller
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface speed_loop_controller_if
  import motor_pkg::*;
#(
  parameter int COUNT_W = c_COUNT_W,
  parameter int DUTY_W  = c_DUTY_W
) ();

  logic               enable;
  logic [COUNT_W-1:0] target_speed;
  logic [COUNT_W-1:0] encoder_count;
  logic               count_clear;
  logic [COUNT_W-1:0] measured_speed;
  logic               speed_valid;
  logic [DUTY_W-1:0]  duty;
  logic               pwm_out;
  logic               fault;

  modport master (
    output enable, target_speed, encoder_count,
    input  count_clear, measured_speed, speed_valid, duty, pwm_out, fault
  );

  modport slave (
    input  enable, target_speed, encoder_count,
    output count_clear, measured_speed, speed_valid, duty, pwm_out, fault
  );

endinterface

`default_nettype wire

// File: rtl/pwm_generator.sv
// ============================================================================
// Module      : pwm_generator
// Description : Free-running PWM. A DUTY_W-bit counter is compared against a
//               shadow copy of the duty that only reloads when the counter
//               wraps, so a duty change never chops a period in half.
// Ports       : clock   - system clock, rising edge
//               reset_n - asynchronous active-low reset
//               i_duty  - duty command (high cycles per 2^DUTY_W)
//               o_pwm   - registered PWM drive
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_generator
  import motor_pkg::*;
#(
  parameter int DUTY_W = c_DUTY_W
) (
  input  wire logic              clock,
  input  wire logic              reset_n,
  input  wire logic [DUTY_W-1:0] i_duty,
  output logic                   o_pwm
);

  localparam logic [DUTY_W-1:0] c_CNT_MAX = '1;

  logic [DUTY_W-1:0] r_cnt;
  logic [DUTY_W-1:0] r_shadow;
  logic              r_pwm;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_pwm    <= 1'b0;
    end else begin
      r_cnt <= r_cnt + DUTY_W'(1);
      // Reload as the counter rolls over to 0: the new period starts clean.
      if (r_cnt == c_CNT_MAX) begin
        r_shadow <= i_duty;
      end
      r_pwm <= (r_cnt < r_shadow);
    end
  end

  assign o_pwm = r_pwm;

endmodule

`default_nettype wire

// File: rtl/speed_loop_controller.sv
// ============================================================================
// Module      : speed_loop_controller
// Description : Closed-loop speed sequencer. Each loop clears the encoder
//               counter, times a WINDOW_CYCLES measurement window, captures
//               the count as measured speed and applies a saturating
//               proportional step (error >>> GAIN_SHIFT) to the PWM duty.
//               Loop period is WINDOW_CYCLES + 3 cycles.
// Ports       : clock   - system clock, rising edge
//               reset_n - asynchronous active-low reset
//               bus     - speed_loop_controller_if.slave (enable,
//                         target_speed, encoder_count in; count_clear,
//                         measured_speed, speed_valid, duty, pwm_out,
//                         fault out)
// Config      : `define STALL_DETECT_EN adds a stall counter: STALL_WINDOWS
//               consecutive windows at full duty with zero speed raise a
//               sticky fault, zero the duty and park the loop in IDLE until
//               enable drops. Without it fault is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module speed_loop_controller
  import motor_pkg::*;
#(
  parameter int WINDOW_CYCLES = c_WINDOW_CYCLES,  // minimum 2
  parameter int COUNT_W       = c_COUNT_W,
  parameter int DUTY_W        = c_DUTY_W,
  parameter int GAIN_SHIFT    = c_GAIN_SHIFT,
  parameter int STALL_WINDOWS = c_STALL_WINDOWS
) (
  input  wire logic              clock,
  input  wire logic              reset_n,
  speed_loop_controller_if.slave bus
);

  localparam int                WIN_W      = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0]  c_WIN_LOAD = WIN_W'(WINDOW_CYCLES - 1);
  localparam int                c_DUTY_MAX = (1 << DUTY_W) - 1;

  loop_state_t         r_state;
  loop_state_t         w_state_next;
  logic [WIN_W-1:0]    r_win;
  logic [COUNT_W-1:0]  r_meas;
  logic                r_speed_valid;
  logic [DUTY_W-1:0]   r_duty;
  logic [DUTY_W-1:0]   w_duty_next;
  logic signed [COUNT_W:0] w_err;
  logic signed [COUNT_W:0] w_step;
  logic                w_count_clear;
  logic                w_measure;
  logic                w_capture;
  logic                w_update;
  logic                w_stall_trip;
  logic                w_fault;
  logic                w_pwm;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (bus.enable && !w_fault) w_state_next = ST_CLEAR;
      ST_CLEAR:   w_state_next = ST_MEASURE;
      ST_MEASURE: if (r_win == '0) w_state_next = ST_CAPTURE;
      ST_CAPTURE: w_state_next = w_stall_trip ? ST_IDLE : ST_UPDATE;
      ST_UPDATE:  w_state_next = ST_CLEAR;
      default:    w_state_next = ST_IDLE;
    endcase
    // Dropping enable abandons whatever is in flight; re-enable always
    // restarts from a fresh CLEAR so a partial window is never captured.
    if (!bus.enable) begin
      w_state_next = ST_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state-decoded controls
  // --------------------------------------------------------------------------
  always_comb begin
    w_count_clear = 1'b0;
    w_measure     = 1'b0;
    w_capture     = 1'b0;
    w_update      = 1'b0;
    case (r_state)
      ST_CLEAR:   w_count_clear = 1'b1;
      ST_MEASURE: w_measure     = 1'b1;
      ST_CAPTURE: w_capture     = bus.enable;
      ST_UPDATE:  w_update      = bus.enable;
      default:    ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Proportional step. err is one bit wider than the operands so that
  // 127 - (-128) and -128 - 127 are both representable.
  // --------------------------------------------------------------------------
  assign w_err  = {bus.target_speed[COUNT_W-1], bus.target_speed}
                - {r_meas[COUNT_W-1], r_meas};
  assign w_step = w_err >>> GAIN_SHIFT;
  assign w_duty_next = DUTY_W'(sat_add(int'(r_duty), int'(w_step), c_DUTY_MAX));

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_win         <= '0;
      r_meas        <= '0;
      r_speed_valid <= 1'b0;
      r_duty        <= '0;
    end else begin
      if (w_count_clear) begin
        r_win <= c_WIN_LOAD;
      end else if (w_measure) begin
        r_win <= r_win - WIN_W'(1);
      end

      r_speed_valid <= w_capture;
      if (w_capture) begin
        r_meas <= bus.encoder_count;
      end

      if (!bus.enable || w_stall_trip) begin
        r_duty <= '0;
      end else if (w_update) begin
        r_duty <= w_duty_next;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stall detection
  // --------------------------------------------------------------------------
`ifdef STALL_DETECT_EN
  localparam int               SC_W         = $clog2(STALL_WINDOWS + 1);
  localparam logic [SC_W-1:0]  c_STALL_LAST = SC_W'(STALL_WINDOWS - 1);

  logic [SC_W-1:0] r_stall_cnt;
  logic            r_fault;
  logic            w_stall_win;

  // Full drive yet the encoder saw nothing over the whole window.
  assign w_stall_win  = w_capture && (r_duty == DUTY_W'(c_DUTY_MAX))
                        && (bus.encoder_count == '0);
  assign w_stall_trip = w_stall_win && (r_stall_cnt == c_STALL_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_fault     <= 1'b0;
    end else if (!bus.enable) begin
      r_stall_cnt <= '0;
      r_fault     <= 1'b0;
    end else if (w_capture) begin
      if (w_stall_trip) begin
        r_stall_cnt <= '0;
        r_fault     <= 1'b1;
      end else if (w_stall_win) begin
        r_stall_cnt <= r_stall_cnt + SC_W'(1);
      end else begin
        r_stall_cnt <= '0;
      end
    end
  end

  assign w_fault = r_fault;
`else
  assign w_stall_trip = 1'b0;
  // No detector in this build: the comparison is constant false, so fault
  // is permanently low.
  assign w_fault      = (STALL_WINDOWS < 0);
`endif

  // --------------------------------------------------------------------------
  // PWM output stage
  // --------------------------------------------------------------------------
  pwm_generator #(
    .DUTY_W (DUTY_W)
  ) u_pwm (
    .clock   (clock),
    .reset_n (reset_n),
    .i_duty  (r_duty),
    .o_pwm   (w_pwm)
  );

  assign bus.count_clear    = w_count_clear;
  assign bus.measured_speed = r_meas;
  assign bus.speed_valid    = r_speed_valid;
  assign bus.duty           = r_duty;
  assign bus.pwm_out        = w_pwm;
  assign bus.fault          = w_fault;

endmodule

`default_nettype wire

// File: tb/tb_speed_loop_controller.sv
// ============================================================================
// Module      : tb_speed_loop_controller
// Description : Self-checking bench for speed_loop_controller. A loop-position
//               model (cycle offset within the WINDOW_CYCLES+3 loop) and a
//               PWM phase model predict every output each cycle; literal
//               expectations pin loop timing, gain, saturation, enable drop,
//               reset and PWM averaging. STALL_DETECT_EN adds a stall check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_speed_loop_controller;

  localparam int W    = 10;
  localparam int CW   = 8;
  localparam int DW   = 8;
  localparam int G    = 2;
  localparam int SW   = 4;
  localparam int DMAX = (1 << DW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              en;
  logic signed [7:0] tgt;
  logic signed [7:0] enc;

  speed_loop_controller_if #(.COUNT_W(CW), .DUTY_W(DW)) bus ();

  assign bus.enable        = en;
  assign bus.target_speed  = tgt;
  assign bus.encoder_count = enc;

  speed_loop_controller #(
    .WINDOW_CYCLES (W),
    .COUNT_W       (CW),
    .DUTY_W        (DW),
    .GAIN_SHIFT    (G),
    .STALL_WINDOWS (SW)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------------------
  // Reference model. pos = cycles since the last count_clear (-1 = idle);
  // capture happens at pos W+1, duty update at pos W+2.
  // ------------------------------------------------------------------------
  int pos, m_duty, m_meas, m_sv, m_fault, m_shadow, m_pwm, ph;
  longint cyc;
`ifdef STALL_DETECT_EN
  int m_stall;
`endif

  function automatic int floor_shift(input int e);
    int d;
    d = 1 << G;
    if (e >= 0) return e / d;
    return -((-e + d - 1) / d);
  endfunction

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > DMAX) return DMAX;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos = -1; m_duty = 0; m_meas = 0; m_sv = 0; m_fault = 0;
      m_shadow = 0; m_pwm = 0; cyc = 0;
`ifdef STALL_DETECT_EN
      m_stall = 0;
`endif
    end else begin
      // PWM: phase of the period counter just before this edge.
      ph = int'(cyc % (DMAX + 1));
      m_pwm = (ph < m_shadow) ? 1 : 0;
      if (ph == DMAX) m_shadow = m_duty;
      cyc++;

      m_sv = 0;
      if (!en) begin
        pos = -1; m_duty = 0; m_fault = 0;
`ifdef STALL_DETECT_EN
        m_stall = 0;
`endif
      end else if (pos < 0) begin
        if (m_fault == 0) pos = 0;
      end else if (pos == W + 1) begin
        m_meas = int'(enc);
        m_sv = 1;
`ifdef STALL_DETECT_EN
        if (m_duty == DMAX && m_meas == 0) m_stall++;
        else m_stall = 0;
        if (m_stall == SW) begin
          m_fault = 1; m_duty = 0; m_stall = 0; pos = -1;
        end else begin
          pos++;
        end
`else
        pos++;
`endif
      end else if (pos == W + 2) begin
        m_duty = clamp(m_duty + floor_shift(int'(tgt) - m_meas));
        pos = 0;
      end else begin
        pos++;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("count_clear",    int'(bus.count_clear), (pos == 0) ? 1 : 0);
      check("measured_speed", int'($signed(bus.measured_speed)), m_meas);
      check("speed_valid",    int'(bus.speed_valid), m_sv);
      check("duty",           int'(bus.duty), m_duty);
      check("pwm_out",        int'(bus.pwm_out), m_pwm);
      check("fault",          int'(bus.fault), m_fault);
    end
  end

  // ------------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------------
  int hi;

  initial begin
    en = 1'b1; tgt = 8'sd60; enc = 8'sd20;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count_clear", int'(bus.count_clear), 0);
    check("rst_measured",    int'(bus.measured_speed), 0);
    check("rst_speed_valid", int'(bus.speed_valid), 0);
    check("rst_duty",        int'(bus.duty), 0);
    check("rst_pwm",         int'(bus.pwm_out), 0);
    check("rst_fault",       int'(bus.fault), 0);

    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Loop timing and gain: 60-20=40, >>>2 = 10 per loop.
    tick(1);
    check("first_clear", int'(bus.count_clear), 1);
    tick(12);
    check("valid_12_after_clear", int'(bus.speed_valid), 1);
    check("captured_20", int'($signed(bus.measured_speed)), 20);
    tick(1);
    check("second_clear_13", int'(bus.count_clear), 1);
    check("duty_after_upd1", int'(bus.duty), 10);
    tick(13);
    check("duty_after_upd2", int'(bus.duty), 20);

    // Upper saturation: err=255 -> +63 per loop.
    tgt = 8'sd127; enc = 8'sh80;
    tick(52);
    check("duty_sat_255", int'(bus.duty), 255);
    tick(13);
    check("duty_hold_255", int'(bus.duty), 255);

    // Lower saturation: err=-255 -> -64 per loop.
    tgt = 8'sh80; enc = 8'sd127;
    tick(52);
    check("duty_sat_0", int'(bus.duty), 0);
    tick(13);
    check("duty_hold_0", int'(bus.duty), 0);

    // Enable dropped in the 5th MEASURE cycle.
    tgt = 8'sd100; enc = 8'sd50;
    tick(5);
    en = 1'b0;
    tick(1);
    check("drop_no_clear", int'(bus.count_clear), 0);
    check("drop_duty_0", int'(bus.duty), 0);
    check("drop_meas_hold", int'($signed(bus.measured_speed)), 127);
    tick(3);
    en = 1'b1;
    tick(1);
    check("reenable_clear", int'(bus.count_clear), 1);

    // PWM: err=128 -> +32 per loop up to 128, then -64 down to 64.
    tgt = 8'sd100; enc = 8'shE4;
    tick(52);
    check("duty_128", int'(bus.duty), 128);
    tgt = 8'sh80; enc = 8'sd127;
    tick(13);
    check("duty_64", int'(bus.duty), 64);
    tgt = 8'sd0; enc = 8'sd0;
    tick(300);
    hi = 0;
    for (int i = 0; i < 512; i++) begin
      tick(1);
      hi += int'(bus.pwm_out);
    end
    check("pwm_high_512", hi, 128);

    // Randomised run with one asynchronous reset in the middle.
    for (int i = 0; i < 2500; i++) begin
      if (en) begin
        if ($urandom_range(0, 99) < 2) en = 1'b0;
      end else if ($urandom_range(0, 99) < 40) begin
        en = 1'b1;
      end
      if ($urandom_range(0, 99) < 10) tgt = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) < 10) begin
        case ($urandom_range(0, 3))
          0: enc = 8'sh80;
          1: enc = 8'sd127;
          default: enc = 8'($urandom_range(0, 255));
        endcase
      end
      if (i == 1200) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count_clear", int'(bus.count_clear), 0);
        check("arst_duty",        int'(bus.duty), 0);
        check("arst_measured",    int'(bus.measured_speed), 0);
        check("arst_speed_valid", int'(bus.speed_valid), 0);
        check("arst_pwm",         int'(bus.pwm_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      tick(1);
    end

`ifdef STALL_DETECT_EN
    en = 1'b1; tgt = 8'sd127; enc = 8'sh80;
    tick(13 * 7);
    enc = 8'sd0;
    begin
      int waited;
      waited = 0;
      while (!bus.fault && waited < 13 * 8) begin
        tick(1);
        waited++;
      end
      check("stall_fault_set", int'(bus.fault), 1);
      check("stall_duty_0", int'(bus.duty), 0);
    end
    en = 1'b0;
    tick(1);
    check("stall_fault_clr", int'(bus.fault), 0);
    en = 1'b1;
    tick(20);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/speed_loop_controller.md
Name: speed_loop_controller

Overview:
Closed-loop sequencer for the motor encoder speed datapath. It times each measurement window and clears the encoder up/down counter at window start. At window end it captures the count as the measured speed, then updates a PWM duty with a saturating proportional step toward a target speed. The block sits between the encoder counter and the motor driver and replaces the free-running window clock with an explicitly sequenced window.

Parameters:
WINDOW_CYCLES, 50000, clock cycles per measurement window (1 ms at 50 MHz); minimum 2
COUNT_W, 8, width of encoder count, target and measured speed (two's complement)
DUTY_W, 8, width of PWM duty and PWM period counter
GAIN_SHIFT, 2, proportional gain as arithmetic right shift of the error
STALL_WINDOWS, 4, consecutive stalled windows before fault (optional feature only)

Ports:
clock  input  1  system clock, all logic rising-edge
reset_n  input  1  asynchronous active-low reset
enable  input  1  loop run request, level-sensitive
target_speed  input  COUNT_W  signed target counts per window, sampled in UPDATE
encoder_count  input  COUNT_W  signed count from encoder up/down counter
count_clear  output  1  one-cycle synchronous clear pulse to the encoder counter
measured_speed  output  COUNT_W  last captured encoder_count
speed_valid  output  1  one-cycle pulse when measured_speed updates
duty  output  DUTY_W  current duty command
pwm_out  output  1  PWM drive to motor
fault  output  1  stall fault flag

Behaviour:
- Reset values: count_clear=0, measured_speed=0, speed_valid=0, duty=0, pwm_out=0, fault=0, FSM=IDLE, window counter=0.
- FSM states: IDLE, CLEAR, MEASURE, CAPTURE, UPDATE.
- IDLE: duty held at 0. Moves to CLEAR when enable=1.
- CLEAR (1 cycle): count_clear=1, window counter loaded with WINDOW_CYCLES-1. Moves to MEASURE.
- MEASURE (exactly WINDOW_CYCLES cycles): counter decrements each cycle. When the counter equals 0, moves to CAPTURE.
- CAPTURE (1 cycle): measured_speed<=encoder_count, speed_valid=1 in the following cycle. Moves to UPDATE.
- UPDATE (1 cycle):
  - err = sign-extended target_speed minus sign-extended measured_speed, COUNT_W+1 bits.
  - step = err >>> GAIN_SHIFT (arithmetic shift).
  - duty <= clamp(duty + step, 0, 2^DUTY_W-1). Computation uses a width of max(DUTY_W, COUNT_W+1)+2.
  - Moves to CLEAR.
- Loop period = WINDOW_CYCLES+3 cycles. count_clear pulses are spaced exactly by this period.
- enable deasserted in any non-IDLE state: the next state is IDLE and duty<=0. A window in progress is discarded with no capture and no speed_valid. measured_speed holds its last value.
- enable reasserted in IDLE: a fresh CLEAR is issued, so no partial window is ever captured.
- Async reset mid-window: all outputs return to reset values immediately. No count_clear is issued until enable is seen after reset release.
- Saturation: duty never wraps. Large positive error at duty=255 stays at 255; negative error at duty=0 stays at 0.
- measured_speed is captured raw. The negative value -128 is legal and participates in err without overflow.
- Sub-module pwm_generator:
  - Free-running DUTY_W counter. pwm_out = (pwm_cnt < duty_shadow), registered.
  - duty_shadow loads duty when pwm_cnt wraps to 0, giving glitch-free updates.
  - duty=0 gives pwm_out constant 0. duty=255 gives high for 255 of 256 cycles.

Optional Feature:
Macro STALL_DETECT_EN.
- Defined: a stall window is one where duty = 2^DUTY_W-1 at CAPTURE and measured_speed = 0.
  - After STALL_WINDOWS consecutive stall windows, fault<=1, duty<=0, FSM goes to IDLE.
  - fault is sticky while enable=1. The FSM stays in IDLE while fault=1.
  - fault clears only when enable=0 or on reset.
  - Any non-stall window resets the stall counter.
- Not defined: no stall counter exists, fault is tied to 0, and the FSM is unchanged.

Decomposition:
- Shared package motor_pkg:
  - FSM state enum (IDLE, CLEAR, MEASURE, CAPTURE, UPDATE) as 3-bit encoding.
  - Default constants for WINDOW_CYCLES, COUNT_W, DUTY_W.
  - A saturating-add helper function.
- One sub-module: pwm_generator (clock, reset_n, duty, pwm_out).
- The stall counter lives inline, under the macro.

Test Plan:
- Reset with enable=1, WINDOW_CYCLES=10 -> first count_clear one cycle after reset release, then every 13 cycles; speed_valid 12 cycles after each clear.
- encoder_count=20, target=60, GAIN_SHIFT=2, duty=0 -> after first UPDATE duty=10; with encoder_count held at 20, duty=20 after second UPDATE.
- target=127, encoder_count=-128, duty=250 -> duty saturates at 255; target=-128, encoder_count=127, duty=10 -> duty=0.
- enable dropped at cycle 5 of MEASURE -> IDLE next cycle, duty=0, no speed_valid, measured_speed unchanged; re-enable -> count_clear next cycle.
- duty=128 with pwm counter mid-period, UPDATE writes duty=64 -> pwm_out keeps 128/256 high until wrap, then 64/256.
- STALL_DETECT_EN defined, STALL_WINDOWS=4, duty=255, encoder_count=0 -> fault=1 and duty=0 after 4th CAPTURE; enable low for one cycle -> fault=0.
